// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM encoding,
// data width and default response latency.
package mips_mem_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous byte-enabled write, with the read
// word sampled on the same enabled edge. Contents have no reset.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rdata only matters for loads, so read-before-write ordering is harmless.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the CPU MEM stage. One request in
// flight; the memory access happens on the edge that enters RESP.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output state_t            fsm_state
);

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both high; the CPU holds req_* stable until then, and
    // rsp_valid is a single-cycle pulse with no back-pressure.

    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic              accept;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [3:0]        cap_be;
    logic              arr_en;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [3:0]        arr_be;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = (state != WAIT);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= 4'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY > 1) ? WAIT : RESP;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (accept) begin
                    state_nxt = (LATENCY > 1) ? WAIT : RESP;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY 1 the acceptance edge is also the edge entering RESP, so the
    // array must see the live request rather than the capture registers.
    always_comb begin
        if (LATENCY == 1) begin
            arr_en    = rst_n && accept;
            arr_we    = req_we;
            arr_addr  = req_addr;
            arr_wdata = req_wdata;
            arr_be    = req_be;
        end else begin
            arr_en    = rst_n && (state == WAIT) && (cnt == 3'd0);
            arr_we    = cap_we;
            arr_addr  = cap_addr;
            arr_wdata = cap_wdata;
            arr_be    = cap_be;
        end
    end

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .be   (arr_be),
        .rdata(arr_rdata)
    );

    assign rsp_rdata = (state == RESP && !cap_we) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    localparam int AW = 9;
    localparam int L0 = 2;
    localparam int L1 = 1;
    localparam int L2 = 4;

    logic              clk;
    logic              rst_n;
    logic [2:0]        req_valid;
    logic [2:0]        req_we;
    logic [2:0][AW-1:0] req_addr;
    logic [2:0][31:0]  req_wdata;
    logic [2:0][3:0]   req_be;
    logic [2:0]        req_ready;
    logic [2:0]        rsp_valid;
    logic [2:0][31:0]  rsp_rdata;
    logic [2:0]        busy;
    logic [2:0][1:0]   fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.ADDR_W(AW), .LATENCY(L0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .fsm_state(fsm_state[0])
    );
    dmem_responder #(.ADDR_W(AW), .LATENCY(L1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .fsm_state(fsm_state[1])
    );
    dmem_responder #(.ADDR_W(AW), .LATENCY(L2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .busy(busy[2]), .fsm_state(fsm_state[2])
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return L0;
            1:       return L1;
            default: return L2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // A request accepted at edge e is seen as a response at edge e+LATENCY;
    // the responder is free to accept again at that same edge.
    int             edge_n;
    logic           pend    [3];
    int             due     [3];
    logic           p_we    [3];
    logic [AW-1:0]  p_addr  [3];
    logic [31:0]    p_wdata [3];
    logic [3:0]     p_be    [3];
    logic [31:0]    mem_m   [3][512];
    logic [3:0]     known   [3][512];

    initial begin
        edge_n = 0;
        for (int d = 0; d < 3; d++) begin
            pend[d] = 1'b0;
            due[d]  = 0;
            for (int a = 0; a < 512; a++) begin
                mem_m[d][a] = 32'h0;
                known[d][a] = 4'h0;
            end
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) edge_n++;
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) pend[d] = 1'b0;
            end else if (clk) begin
                for (int d = 0; d < 3; d++) begin
                    if (pend[d] && due[d] == edge_n) begin
                        if (p_we[d]) begin
                            for (int i = 0; i < 4; i++) begin
                                if (p_be[d][i]) mem_m[d][p_addr[d]][8*i +: 8] = p_wdata[d][8*i +: 8];
                            end
                            known[d][p_addr[d]] = known[d][p_addr[d]] | p_be[d];
                        end
                        pend[d] = 1'b0;
                    end
                    if (req_valid[d] && !pend[d]) begin
                        pend[d]    = 1'b1;
                        due[d]     = edge_n + lat_of(d);
                        p_we[d]    = req_we[d];
                        p_addr[d]  = req_addr[d];
                        p_wdata[d] = req_wdata[d];
                        p_be[d]    = req_be[d];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic        ev;
        logic        chk_rd;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 3; d++) begin
                    ev     = pend[d] && (due[d] == edge_n + 1);
                    er     = 32'h0;
                    chk_rd = 1'b1;
                    if (ev && !p_we[d]) begin
                        if (known[d][p_addr[d]] == 4'hF) er = mem_m[d][p_addr[d]];
                        else chk_rd = 1'b0;
                    end
                    check($sformatf("rsp_valid[%0d]@%0d", d, edge_n), rsp_valid[d], ev);
                    if (chk_rd) check($sformatf("rsp_rdata[%0d]@%0d", d, edge_n), rsp_rdata[d], er);
                    check($sformatf("req_ready[%0d]@%0d", d, edge_n), req_ready[d],
                          !pend[d] || (due[d] == edge_n + 1));
                    check($sformatf("busy[%0d]@%0d", d, edge_n), busy[d], pend[d]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int d, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] w, input logic [3:0] be);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = w;
        req_be[d]    = be;
    endtask

    // Present a request, wait for acceptance, then count cycles to the response.
    task automatic do_req(input int d, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] w, input logic [3:0] be,
                          output logic [31:0] rd, output int lat);
        int  n;
        bit  done;
        drive(d, we, a, w, be);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) check("accept_timeout", {31'b0, req_ready[d]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat  = 0;
        rd   = 32'h0;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            if (rsp_valid[d]) begin
                lat  = k;
                rd   = rsp_rdata[d];
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic req_check(input int d, input logic we, input logic [AW-1:0] a,
                             input logic [31:0] w, input logic [3:0] be,
                             input logic [31:0] exp_rd, input string name);
        logic [31:0] rd;
        int          lat;
        do_req(d, we, a, w, be, rd, lat);
        check({name, "_lat"}, lat, lat_of(d));
        check({name, "_rdata"}, rd, exp_rd);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] b2b_exp [3];
    logic [AW-1:0] b2b_addr [3];

    initial begin
        int          n_wait;
        int          pulses;
        int          lat;
        logic [31:0] rd;

        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ready[%0d]", d), req_ready[d], 32'd1);
            check($sformatf("reset_busy[%0d]", d), busy[d], 32'd0);
            check($sformatf("reset_rsp_valid[%0d]", d), rsp_valid[d], 32'd0);
            check($sformatf("reset_rdata[%0d]", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset_state[%0d]", d), fsm_state[d], IDLE);
        end
        #21 rst_n = 1'b1;

        // Full store then load, LATENCY 2.
        req_check(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0, "st010");
        req_check(0, 1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF, "ld010");
        req_check(0, 1'b0, 9'h010, 32'h0, 4'hF, 32'hDEADBEEF, "ld010_be_ignored");

        // Partial store on lanes 0 and 2.
        req_check(0, 1'b1, 9'h020, 32'h11223344, 4'hF, 32'h0, "st020");
        req_check(0, 1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, 32'h0, "st020_part");
        req_check(0, 1'b0, 9'h020, 32'h0, 4'h0, 32'h11BB33DD, "ld020");

        // Store with no lanes enabled still responds and leaves memory alone.
        req_check(0, 1'b1, 9'h040, 32'h12345678, 4'hF, 32'h0, "st040");
        req_check(0, 1'b1, 9'h040, 32'hFFFFFFFF, 4'h0, 32'h0, "st040_be0");
        req_check(0, 1'b0, 9'h040, 32'h0, 4'h0, 32'h12345678, "ld040");

        // Top word address.
        req_check(0, 1'b1, 9'h1FF, 32'hA5A50F0F, 4'hF, 32'h0, "st1ff");
        req_check(0, 1'b0, 9'h1FF, 32'h0, 4'h0, 32'hA5A50F0F, "ld1ff");

        // LATENCY 1: preload, then three loads held back to back.
        b2b_addr[0] = 9'h100; b2b_exp[0] = 32'h01010101;
        b2b_addr[1] = 9'h101; b2b_exp[1] = 32'h02020202;
        b2b_addr[2] = 9'h102; b2b_exp[2] = 32'hAA030303;
        req_check(1, 1'b1, 9'h100, 32'h01010101, 4'hF, 32'h0, "st100");
        req_check(1, 1'b1, 9'h101, 32'h02020202, 4'hF, 32'h0, "st101");
        req_check(1, 1'b1, 9'h102, 32'h03030303, 4'hF, 32'h0, "st102");
        req_check(1, 1'b1, 9'h102, 32'hAA000000, 4'b1000, 32'h0, "st102_top");
        drive(1, 1'b0, b2b_addr[0], 32'h0, 4'h0);
        check("b2b_ready_first", req_ready[1], 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("b2b_valid%0d", k), rsp_valid[1], 32'd1);
            check($sformatf("b2b_rdata%0d", k), rsp_rdata[1], b2b_exp[k]);
            check($sformatf("b2b_ready%0d", k), req_ready[1], 32'd1);
            if (k < 2) drive(1, 1'b0, b2b_addr[k+1], 32'h0, 4'h0);
            else req_valid[1] = 1'b0;
        end
        @(negedge clk);
        check("b2b_after", rsp_valid[1], 32'd0);

        // LATENCY 4: a second request held through WAIT is taken only in RESP.
        drive(2, 1'b1, 9'h050, 32'hCAFEF00D, 4'hF);
        check("hold_ready_first", req_ready[2], 32'd1);
        @(negedge clk);
        drive(2, 1'b0, 9'h050, 32'h0, 4'h0);
        n_wait = 0;
        for (int k = 0; k < 10 && !req_ready[2]; k++) begin
            n_wait++;
            @(negedge clk);
        end
        check("hold_wait_cycles", n_wait, 32'd3);
        check("hold_first_rsp", rsp_valid[2], 32'd1);
        check("hold_first_rdata", rsp_rdata[2], 32'h0);
        pulses = 1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        lat = 0;
        rd  = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            if (rsp_valid[2]) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    rd  = rsp_rdata[2];
                end
            end
            @(negedge clk);
        end
        check("hold_second_lat", lat, 32'd4);
        check("hold_second_rdata", rd, 32'hCAFEF00D);
        check("hold_pulses", pulses, 32'd2);
        req_check(2, 1'b0, 9'h050, 32'h0, 4'h0, 32'hCAFEF00D, "ld050_again");

        // Reset during WAIT drops the store.
        req_check(0, 1'b1, 9'h030, 32'h0, 4'hF, 32'h0, "st030_zero");
        drive(0, 1'b1, 9'h030, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rst_busy_before", busy[0], 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_now", busy[0], 32'd0);
        check("rst_rsp_now", rsp_valid[0], 32'd0);
        check("rst_ready_now", req_ready[0], 32'd1);
        check("rst_rdata_now", rsp_rdata[0], 32'd0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        check("rst_no_pulse", pulses, 32'd0);
        req_check(0, 1'b0, 9'h030, 32'h0, 4'h0, 32'h00000000, "ld030");
        req_check(0, 1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF, "ld010_after_rst");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
